tx_packet_arbiter: RTL
======================

# tx_packet_arbiter

Shares the single write port of the tx FIFO (toward the FT245 interface) between two requesters: the housekeeping path (MCP3008 32-bit sample words) and the CCD pixel byte stream. It frames each grant as a self-describing packet (tag byte, payload, and for CCD a trailer) so host software can demultiplex the byte stream. It sits between the top-level controller/CCD readout and the tx FIFO write side, in the system clock domain. It replaces direct `tx_fifo_winc`/`tx_fifo_wdata` driving from the top-level state machine.

## Interface
Parameters:
- `HK_TAG`, 8'hA5, tag byte opening a housekeeping packet
- `CCD_TAG`, 8'hC3, tag byte opening a CCD burst
- `BURST_LEN`, 64, CCD payload bytes per burst; legal range 1..127

Ports:
- `clk`  in  1  system clock; the block uses this one clock only
- `rst`  in  1  reset, asynchronous, active-high
- `hk_req`  in  1  housekeeping word pending; held until `hk_ack`
- `hk_data`  in  32  housekeeping word; stable while `hk_req`=1
- `hk_ack`  out  1  one-cycle pulse when `hk_data` is captured
- `ccd_valid`  in  1  `ccd_data` valid
- `ccd_data`  in  8  pixel byte
- `ccd_last`  in  1  marks the final byte of a frame; qualified by `ccd_valid`
- `ccd_ready`  out  1  byte accepted when `ccd_valid & ccd_ready`
- `fifo_wdata`  out  8  tx FIFO write data
- `fifo_winc`  out  1  tx FIFO write strobe; a byte commits on each `clk` edge where it is 1
- `fifo_wfull`  in  1  tx FIFO full
- `busy`  out  1  high when state is not IDLE

## Operation
- States: IDLE, HK_HDR, HK_B0, HK_B1, HK_B2, HK_B3, CCD_HDR, CCD_DATA, CCD_PAD, CCD_TRL.
- IDLE arbitration uses round-robin with a registered `last_grant` (reset value = CCD, so housekeeping wins first).
  - Only `hk_req`: grant HK.
  - Only `ccd_valid`: grant CCD.
  - Both asserted: grant the requester not named by `last_grant`.
  - `last_grant` updates on every grant.
- HK grant: `hk_data` is latched into an internal 32-bit register and `hk_ack`=1 for that cycle; go to HK_HDR.
- HK packet sequence: HK_HDR writes `HK_TAG`, then HK_B0..HK_B3 write bytes [7:0], [15:8], [23:16], [31:24] (LSB first), then IDLE.
- CCD grant: clear the 7-bit `cnt` and `last_seen`; go to CCD_HDR, which writes `CCD_TAG`, then CCD_DATA.
- CCD_DATA:
  - `ccd_ready = !fifo_wfull`; `fifo_wdata = ccd_data`; `fifo_winc = ccd_valid & !fifo_wfull`.
  - Each accepted byte increments `cnt`.
  - On accepting `ccd_last`: set `last_seen`; go to CCD_PAD if `cnt+1 < BURST_LEN`, else CCD_TRL.
  - On accepting byte number `BURST_LEN` without `ccd_last`: go to CCD_TRL.
- CCD_PAD: writes 8'h00 until `BURST_LEN` payload bytes have been written in total; `cnt` does not increment on pad bytes; then CCD_TRL.
- CCD_TRL: writes `{last_seen, cnt[6:0]}`, where `cnt` is the number of valid pixel bytes (1..BURST_LEN); then IDLE.
- Every CCD burst on the wire is exactly 1 + `BURST_LEN` + 1 bytes.
- A frame longer than `BURST_LEN` spans several bursts. Between bursts the block re-arbitrates in IDLE, so a pending HK packet is interleaved.
- Write strobes:
  - In every write state except CCD_DATA, `fifo_winc = !fifo_wfull`.
  - The state advances only on a committed write; with `fifo_wfull`=1 the block stalls in place with no data loss.
- `ccd_ready`=0 in every state other than CCD_DATA.
- `fifo_wdata`=8'h00 whenever `fifo_winc`=0.

## Timing
- On reset: state=IDLE, `last_grant`=CCD, `cnt`=0, `last_seen`=0. All outputs are 0: `hk_ack`, `ccd_ready`, `fifo_winc`, `fifo_wdata`, `busy`.
- `fifo_winc`, `fifo_wdata`, `ccd_ready` and `busy` are combinational from state and inputs, with no added latency. `hk_ack` is asserted in the IDLE grant cycle.
- Grant latency: a request seen in IDLE causes the first write (tag) in the next cycle.
- HK packet, no backpressure: 1 grant cycle + 5 write cycles, then IDLE. A back-to-back request is regranted at the earliest on cycle 7.
- CCD burst with continuous `ccd_valid`: 1 + 1 + `BURST_LEN` + 1 cycles.
- `hk_req` dropped after a grant has no effect. `hk_req` still high after `hk_ack` is treated as a new request.
- `rst` mid-packet: the partial packet is abandoned and the block returns to IDLE immediately. The tx FIFO is flushed by its own reset, not by this block.

## Test plan
- `hk_req`=1, `hk_data`=32'h11223344, `fifo_wfull`=0 -> writes A5,44,33,22,11 on 5 consecutive cycles; `hk_ack` pulses once in the grant cycle.
- `BURST_LEN`=4; 10 CCD bytes 01..0A, `ccd_last` on 0A -> C3,01..04,04; C3,05..08,04; C3,09,0A,00,00,82.
- `hk_req` and `ccd_valid` asserted together after reset -> HK packet first, then CCD burst. With both persistent, grants alternate HK, CCD, HK.
- `fifo_wfull` held high for 3 cycles during HK_B1 -> `fifo_winc`=0 for those 3 cycles; byte stream unchanged; packet completes 3 cycles later.
- `rst` pulsed during CCD_DATA -> next cycle: `busy`=0, `ccd_ready`=0. The next grant starts a fresh burst with C3 and `cnt` from 0.

Source files
------------

// File: rtl/tx_packet_arbiter.sv
// ---------------------------------------------------------------------------
// tx_packet_arbiter
//
// Purpose:
//   Shares the single write port of the tx FIFO between the housekeeping path
//   (32-bit sample words) and the CCD pixel byte stream. Each grant is written
//   out as a self-describing packet so host software can demultiplex:
//     HK  packet : HK_TAG, word[7:0], word[15:8], word[23:16], word[31:24]
//     CCD burst  : CCD_TAG, BURST_LEN payload bytes (pixels, then 8'h00 pad),
//                  trailer {last_seen, pixel_count[6:0]}
//   Arbitration in IDLE is round-robin on a registered last_grant, which
//   resets to CCD so housekeeping wins the first contest.
//
// Parameters:
//   HK_TAG    : tag byte opening a housekeeping packet
//   CCD_TAG   : tag byte opening a CCD burst
//   BURST_LEN : CCD payload bytes per burst, legal range 1..127
//
// Ports:
//   clk        in   system clock (single clock domain)
//   rst        in   asynchronous active-high reset
//   hk_req     in   housekeeping word pending, held until hk_ack
//   hk_data    in   housekeeping word, stable while hk_req is high
//   hk_ack     out  one-cycle pulse in the cycle hk_data is captured
//   ccd_valid  in   ccd_data valid
//   ccd_data   in   pixel byte
//   ccd_last   in   final byte of a frame, qualified by ccd_valid
//   ccd_ready  out  byte accepted when ccd_valid & ccd_ready
//   fifo_wdata out  tx FIFO write data (8'h00 when not writing)
//   fifo_winc  out  tx FIFO write strobe, one byte commits per high edge
//   fifo_wfull in   tx FIFO full; the block stalls in place while high
//   busy       out  high whenever the state is not IDLE
// ---------------------------------------------------------------------------
module tx_packet_arbiter #(
  parameter logic [7:0]  HK_TAG    = 8'hA5,
  parameter logic [7:0]  CCD_TAG   = 8'hC3,
  parameter int unsigned BURST_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hk_req,
  input  logic [31:0] hk_data,
  output logic        hk_ack,
  input  logic        ccd_valid,
  input  logic [7:0]  ccd_data,
  input  logic        ccd_last,
  output logic        ccd_ready,
  output logic [7:0]  fifo_wdata,
  output logic        fifo_winc,
  input  logic        fifo_wfull,
  output logic        busy
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HK_HDR,
    ST_HK_B0,
    ST_HK_B1,
    ST_HK_B2,
    ST_HK_B3,
    ST_CCD_HDR,
    ST_CCD_DATA,
    ST_CCD_PAD,
    ST_CCD_TRL
  } state_e;

  typedef enum logic {
    GRANT_HK  = 1'b0,
    GRANT_CCD = 1'b1
  } grant_e;

  // Burst length widened to 8 bits so "count + 1" comparisons never wrap,
  // even for BURST_LEN = 127.
  localparam logic [7:0] BURST_LEN_B = 8'(BURST_LEN);

  state_e      state_q,      state_d;
  grant_e      last_grant_q, last_grant_d;
  logic [6:0]  cnt_q,        cnt_d;        // valid pixel bytes in this burst
  logic [6:0]  pos_q,        pos_d;        // payload bytes written (pixels + pad)
  logic        last_seen_q,  last_seen_d;
  logic [31:0] hk_word_q,    hk_word_d;

  logic        write_ok;
  logic        wr_en;
  logic [7:0]  wr_byte;
  logic [7:0]  cnt_inc;
  logic [7:0]  pos_inc;
  logic        grant_hk;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_CCD;
      cnt_q        <= '0;
      pos_q        <= '0;
      last_seen_q  <= 1'b0;
      hk_word_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      pos_q        <= pos_d;
      last_seen_q  <= last_seen_d;
      hk_word_q    <= hk_word_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    pos_d        = pos_q;
    last_seen_d  = last_seen_q;
    hk_word_d    = hk_word_q;
    hk_ack       = 1'b0;
    ccd_ready    = 1'b0;
    wr_en        = 1'b0;
    wr_byte      = 8'h00;

    write_ok = !fifo_wfull;
    cnt_inc  = {1'b0, cnt_q} + 8'd1;
    pos_inc  = {1'b0, pos_q} + 8'd1;

    // Housekeeping wins unless CCD also asks and HK had the previous grant.
    grant_hk = hk_req && (!ccd_valid || (last_grant_q == GRANT_CCD));

    unique case (state_q)
      ST_IDLE: begin
        if (grant_hk) begin
          hk_word_d    = hk_data;
          hk_ack       = 1'b1;
          last_grant_d = GRANT_HK;
          state_d      = ST_HK_HDR;
        end else if (ccd_valid) begin
          cnt_d        = '0;
          pos_d        = '0;
          last_seen_d  = 1'b0;
          last_grant_d = GRANT_CCD;
          state_d      = ST_CCD_HDR;
        end
      end

      // Fixed-byte write states: each advances only when its byte commits.
      ST_HK_HDR: begin
        wr_en   = write_ok;
        wr_byte = HK_TAG;
        if (write_ok) state_d = ST_HK_B0;
      end
      ST_HK_B0: begin
        wr_en   = write_ok;
        wr_byte = hk_word_q[7:0];
        if (write_ok) state_d = ST_HK_B1;
      end
      ST_HK_B1: begin
        wr_en   = write_ok;
        wr_byte = hk_word_q[15:8];
        if (write_ok) state_d = ST_HK_B2;
      end
      ST_HK_B2: begin
        wr_en   = write_ok;
        wr_byte = hk_word_q[23:16];
        if (write_ok) state_d = ST_HK_B3;
      end
      ST_HK_B3: begin
        wr_en   = write_ok;
        wr_byte = hk_word_q[31:24];
        if (write_ok) state_d = ST_IDLE;
      end

      ST_CCD_HDR: begin
        wr_en   = write_ok;
        wr_byte = CCD_TAG;
        if (write_ok) state_d = ST_CCD_DATA;
      end

      // Pixels pass straight through; the FIFO write doubles as the accept.
      ST_CCD_DATA: begin
        ccd_ready = write_ok;
        wr_en     = ccd_valid && write_ok;
        wr_byte   = ccd_data;
        if (wr_en) begin
          cnt_d = cnt_inc[6:0];
          pos_d = pos_inc[6:0];
          if (ccd_last) begin
            last_seen_d = 1'b1;
            state_d     = (cnt_inc < BURST_LEN_B) ? ST_CCD_PAD : ST_CCD_TRL;
          end else if (cnt_inc == BURST_LEN_B) begin
            state_d = ST_CCD_TRL;
          end
        end
      end

      // Short final burst: zero-fill so every burst has the same length on
      // the wire. cnt keeps the pixel count for the trailer.
      ST_CCD_PAD: begin
        wr_en   = write_ok;
        wr_byte = 8'h00;
        if (write_ok) begin
          pos_d = pos_inc[6:0];
          if (pos_inc == BURST_LEN_B) state_d = ST_CCD_TRL;
        end
      end

      ST_CCD_TRL: begin
        wr_en   = write_ok;
        wr_byte = {last_seen_q, cnt_q};
        if (write_ok) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    fifo_winc  = wr_en;
    fifo_wdata = wr_en ? wr_byte : 8'h00;
    busy       = (state_q != ST_IDLE);
  end

endmodule
